// File: rtl/am_similarity_accumulator.sv
// Streams the query and every stored class hypervector segment by segment and
// accumulates popcount(query & class) per class for the AM tree comparator.
module am_similarity_accumulator #(
    parameter int NUM_CLASSES = 26,
    parameter int SEG_W       = 64,
    parameter int NUM_SEGS    = 79,
    parameter int SIM_W       = 13,
    localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int SEG_AW     = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               sim_valid,
    output logic               am_rd_en,
    output logic [CLS_W-1:0]   am_class_addr,
    output logic [SEG_AW-1:0]  am_seg_addr,
    input  logic [SEG_W-1:0]   query_data,
    input  logic [SEG_W-1:0]   am_data,
    output logic [SIM_W-1:0]   similarity_values [0:NUM_CLASSES-1]
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [CLS_W-1:0]  cls;
    logic [SEG_AW-1:0] seg;
    logic [CLS_W-1:0]  cls_d;
    logic              rd_vld_d;
    logic              last_cls;
    logic              last_seg;
    logic [SIM_W:0]    sum;
    logic [SIM_W-1:0]  sum_sat;

    function automatic logic [SIM_W:0] popcnt(input logic [SEG_W-1:0] v);
        logic [SIM_W:0] c;
        c = '0;
        for (int i = 0; i < SEG_W; i++)
            c = c + (SIM_W+1)'(v[i]);
        return c;
    endfunction

    assign last_cls      = (cls == CLS_W'(NUM_CLASSES - 1));
    assign last_seg      = (seg == SEG_AW'(NUM_SEGS - 1));
    assign busy          = (state != S_IDLE);
    assign am_rd_en      = (state == S_RUN);
    assign am_class_addr = cls;
    assign am_seg_addr   = seg;

    // One accumulator updates per cycle; carry-out of the widened sum saturates.
    always_comb begin
        sum     = {1'b0, similarity_values[cls_d]} + popcnt(query_data & am_data);
        sum_sat = sum[SIM_W] ? {SIM_W{1'b1}} : sum[SIM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cls       <= '0;
            seg       <= '0;
            cls_d     <= '0;
            rd_vld_d  <= 1'b0;
            done      <= 1'b0;
            sim_valid <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++)
                similarity_values[k] <= '0;
        end else begin
            rd_vld_d <= (state == S_RUN);
            cls_d    <= cls;
            done     <= 1'b0;
            if (rd_vld_d)
                similarity_values[cls_d] <= sum_sat;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < NUM_CLASSES; k++)
                            similarity_values[k] <= '0;
                        sim_valid <= 1'b0;
                        cls       <= '0;
                        seg       <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Segment-outer, class-inner walk over the AM.
                    if (last_cls) begin
                        cls <= '0;
                        if (last_seg) begin
                            seg   <= '0;
                            state <= S_DRAIN;
                        end else begin
                            seg <= seg + SEG_AW'(1);
                        end
                    end else begin
                        cls <= cls + CLS_W'(1);
                    end
                end
                S_DRAIN: begin
                    done      <= 1'b1;
                    sim_valid <= 1'b1;
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
